// File: rtl/starfield_pkg.sv
// Shared types, register map and helpers for the multi-layer starfield generator.
package starfield_pkg;

    localparam int unsigned X_W     = 11;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned CHAN_W  = 8;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_COLOUR = 2'd1;
    localparam logic [1:0] ADDR_RESEED = 2'd2;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } star_t;

    localparam logic [LFSR_W-1:0] DEF_SEED_X = 16'hBEEF;
    localparam logic [LFSR_W-1:0] DEF_SEED_Y = 16'hACE1;
    localparam logic [LFSR_W-1:0] DEF_SEED_F = 16'hFACE;

    // Fold an LFSR value into the visible column range.
    function automatic logic [X_W-1:0] fold_x(input logic [LFSR_W-1:0] v,
                                              input logic [X_W-1:0]    lim);
        logic [X_W-1:0] t;
        t = v[X_W-1:0];
        return (t >= lim) ? X_W'(t - lim) : t;
    endfunction

    // Fold the low 9 LFSR bits into the visible row range.
    function automatic logic [Y_W-1:0] fold_y(input logic [LFSR_W-1:0] v,
                                              input logic [Y_W-1:0]    lim);
        logic [Y_W-1:0] t;
        t = {1'b0, v[8:0]};
        return (t >= lim) ? Y_W'(t - lim) : t;
    endfunction

    // (base * (level + 1)) >> 8, exact for all 8-bit operands.
    function automatic logic [CHAN_W-1:0] scale8(input logic [CHAN_W-1:0] base,
                                                 input logic [CHAN_W-1:0] level);
        logic [16:0] prod;
        prod = 17'(base) * (17'(level) + 17'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// Combinational next state of the 16-bit right-shifting LFSR shared by all star sources.
module lfsr16_step (
    input  logic [15:0] cur,
    output logic [15:0] nxt_c
);

    assign nxt_c = {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};

endmodule

// File: rtl/starfield_gen.sv
// Multi-layer parallax starfield: LFSR-filled star table, per-frame scroll, twinkle, per-pixel hit.
// Optional STARFIELD_BREATH_EN adds a triangle brightness envelope stepped once per frame.
module starfield_gen
    import starfield_pkg::*;
#(
    parameter int unsigned STAR_COUNT  = 64,
    parameter int unsigned LAYERS      = 2,
    parameter int unsigned HACTIVE     = 1280,
    parameter int unsigned VACTIVE     = 480,
    parameter int unsigned FLICKER_DIV = 6,
    parameter logic [15:0] SEED_X      = DEF_SEED_X,
    parameter logic [15:0] SEED_Y      = DEF_SEED_Y,
    parameter logic [15:0] SEED_F      = DEF_SEED_F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_start,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        init_done,
    output logic        star_hit,
    output logic [7:0]  star_r,
    output logic [7:0]  star_g,
    output logic [7:0]  star_b
);

    localparam int unsigned IDX_W   = (STAR_COUNT > 1) ? $clog2(STAR_COUNT) : 1;
    localparam int unsigned LAYER_W = 2;
    localparam int unsigned STEP_W  = 6;
    localparam int unsigned FCNT_W  = 8;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(STAR_COUNT - 1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYERS - 1);
    localparam logic [X_W-1:0]     HLIM       = X_W'(HACTIVE);
    localparam logic [Y_W-1:0]     VLIM       = Y_W'(VACTIVE);
    localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(FLICKER_DIV - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [15:0]          lfsr_x_q, lfsr_y_q, flicker_q;
    logic [15:0]          lfsr_x_nxt, lfsr_y_nxt, flicker_nxt;
    logic [FCNT_W-1:0]    frame_cnt_q;
    logic                 enable_q, twinkle_q;
    logic [2:0]           speed_q;
    logic [23:0]          colour_q;
    star_t                stars_q [STAR_COUNT];

    logic                 reseed;
    logic                 star_we, step_x, step_y, init_set;
    star_t                cur_star, new_star;
    logic [STEP_W-1:0]    step;
    logic [X_W-1:0]       y_sum;
    logic                 wrap;

    logic                 hit_any, pixel_ok;
    logic [LAYER_W-1:0]   hit_layer;
    logic [7:0]           intensity;
    logic [7:0]           r_c, g_c, b_c;

    lfsr16_step u_lfsr_x (.cur(lfsr_x_q),  .nxt_c(lfsr_x_nxt));
    lfsr16_step u_lfsr_y (.cur(lfsr_y_q),  .nxt_c(lfsr_y_nxt));
    lfsr16_step u_lfsr_f (.cur(flicker_q), .nxt_c(flicker_nxt));

    assign reseed = cfg_we && (cfg_addr == ADDR_RESEED);

    // Star record produced this cycle: fresh placement in INIT, scrolled copy in UPDATE.
    always_comb begin
        cur_star = stars_q[idx_q];
        step     = STEP_W'(speed_q) * (STEP_W'(layer_q) + STEP_W'(1));
        y_sum    = X_W'(cur_star.y) + X_W'(step);
        wrap     = (y_sum >= X_W'(VLIM));
        new_star = cur_star;
        if (state_q == ST_INIT) begin
            new_star.x = fold_x(lfsr_x_q, HLIM);
            new_star.y = fold_y(lfsr_y_q, VLIM);
        end else begin
            new_star.y = wrap ? Y_W'(y_sum - X_W'(VLIM)) : Y_W'(y_sum);
            if (wrap) begin
                new_star.x = fold_x(lfsr_x_q, HLIM);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            layer_q <= layer_d;
        end
    end

    // Walk controller; a reseed write overrides whatever walk is in progress.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        layer_d  = layer_q;
        star_we  = 1'b0;
        step_x   = 1'b0;
        step_y   = 1'b0;
        init_set = 1'b0;
        case (state_q)
            ST_INIT: begin
                star_we = 1'b1;
                step_x  = 1'b1;
                step_y  = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d  = ST_RUN;
                    idx_d    = '0;
                    layer_d  = '0;
                    init_set = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    layer_d = (layer_q == LAST_LAYER) ? '0 : layer_q + LAYER_W'(1);
                end
            end
            ST_RUN: begin
                if (frame_start) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                    layer_d = '0;
                end
            end
            ST_UPDATE: begin
                star_we = 1'b1;
                step_x  = wrap;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    layer_d = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    layer_d = (layer_q == LAST_LAYER) ? '0 : layer_q + LAYER_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
                layer_d = '0;
            end
        endcase
        if (reseed) begin
            state_d  = ST_INIT;
            idx_d    = '0;
            layer_d  = '0;
            star_we  = 1'b0;
            step_x   = 1'b0;
            step_y   = 1'b0;
            init_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAR_COUNT; i++) begin
                stars_q[IDX_W'(i)] <= '0;
            end
        end else if (star_we) begin
            stars_q[idx_q] <= new_star;
        end
    end

    // Position LFSRs; a zero reseed half falls back to the build-time seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_x_q <= SEED_X;
            lfsr_y_q <= SEED_Y;
        end else if (reseed) begin
            lfsr_x_q <= (cfg_wdata[15:0]  == 16'h0) ? SEED_X : cfg_wdata[15:0];
            lfsr_y_q <= (cfg_wdata[31:16] == 16'h0) ? SEED_Y : cfg_wdata[31:16];
        end else begin
            if (step_x) lfsr_x_q <= lfsr_x_nxt;
            if (step_y) lfsr_y_q <= lfsr_y_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q  <= 1'b1;
            twinkle_q <= 1'b1;
            speed_q   <= 3'd0;
            colour_q  <= 24'hFFFF00;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_CTRL: begin
                    enable_q  <= cfg_wdata[0];
                    twinkle_q <= cfg_wdata[1];
                    speed_q   <= cfg_wdata[6:4];
                end
                ADDR_COLOUR: colour_q <= cfg_wdata[23:0];
                default: ;
            endcase
        end
    end

    // Frame divider for the twinkle pattern; counts every frame_start regardless of walk state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            flicker_q   <= SEED_F;
        end else if (frame_start) begin
            if (frame_cnt_q == FCNT_LAST) begin
                frame_cnt_q <= '0;
                flicker_q   <= flicker_nxt;
            end else begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_done <= 1'b0;
        end else if (reseed) begin
            init_done <= 1'b0;
        end else if (init_set) begin
            init_done <= 1'b1;
        end
    end

`ifdef STARFIELD_BREATH_EN
    logic [7:0] level_q;
    logic       falling_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= 8'd0;
            falling_q <= 1'b0;
        end else if (frame_start) begin
            if (!falling_q) begin
                level_q <= level_q + 8'd1;
                if (level_q == 8'd254) falling_q <= 1'b1;
            end else begin
                level_q <= level_q - 8'd1;
                if (level_q == 8'd1) falling_q <= 1'b0;
            end
        end
    end
`endif

    // Priority match: scanning downward leaves the lowest matching index in hit_layer.
    always_comb begin
        hit_any   = 1'b0;
        hit_layer = '0;
        for (int i = STAR_COUNT - 1; i >= 0; i--) begin
            if ((!twinkle_q || flicker_q[4'(i)]) &&
                (stars_q[IDX_W'(i)].x == hcount) &&
                (stars_q[IDX_W'(i)].y == vcount)) begin
                hit_any   = 1'b1;
                hit_layer = LAYER_W'(i % int'(LAYERS));
            end
        end
    end

    always_comb begin
        pixel_ok  = enable_q && init_done && (hcount < HLIM) && (vcount < VLIM) && hit_any;
        intensity = 8'hFF >> (LAST_LAYER - hit_layer);
        r_c       = scale8(colour_q[23:16], intensity);
        g_c       = scale8(colour_q[15:8],  intensity);
        b_c       = scale8(colour_q[7:0],   intensity);
`ifdef STARFIELD_BREATH_EN
        r_c       = scale8(r_c, level_q);
        g_c       = scale8(g_c, level_q);
        b_c       = scale8(b_c, level_q);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            star_hit <= 1'b0;
            star_r   <= 8'd0;
            star_g   <= 8'd0;
            star_b   <= 8'd0;
        end else begin
            star_hit <= pixel_ok;
            star_r   <= pixel_ok ? r_c : 8'd0;
            star_g   <= pixel_ok ? g_c : 8'd0;
            star_b   <= pixel_ok ? b_c : 8'd0;
        end
    end

endmodule
